// File: rtl/in_port_fifo.sv
// Mini SRC input-port front end: synchronizes an asynchronous device strobe,
// buffers device words in a small FIFO and drives the head word onto the bus on PortInout.
module in_port_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] ext_data,
  input  logic                  ext_strobe,
  output logic                  ext_ready,
  input  logic                  PortInout,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  data_valid,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]     wr_ptr;
  logic                  sync1;
  logic                  sync2;
  logic                  strobe_prev;
  logic                  rd_prev;

  logic                  push_req;
  logic                  pop_req;
  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;
  logic [ADDR_W:0]       count_next;

  // A pop in the same cycle frees the slot for a push on a full FIFO; an empty
  // FIFO never bypasses, so a simultaneous pop there is an underflow.
  always_comb begin
    push_req   = sync2 & ~strobe_prev;
    pop_req    = PortInout & ~rd_prev;
    empty      = (count == '0);
    full       = (count == FULL_COUNT);
    do_pop     = pop_req & ~empty;
    do_push    = push_req & (~full | do_pop);
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      strobe_prev <= 1'b0;
      rd_prev     <= 1'b0;
      ext_ready   <= 1'b1;
    end else begin
      sync1       <= ext_strobe;
      sync2       <= sync1;
      strobe_prev <= sync2;
      rd_prev     <= PortInout;
      count       <= count_next;
      ext_ready   <= (count_next < FULL_COUNT);
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !do_pop) overflow  <= 1'b1;
      if (pop_req && empty)            underflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= ext_data;
  end

  assign data_valid = ~empty;
  assign bus_out    = (PortInout && !empty) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_in_port_fifo.sv
// Randomized self-checking bench for in_port_fifo against a queue-based model
// of the port FIFO (3-edge strobe latency, one pop per PortInout assertion).
module tb_in_port_fifo;

  logic        clock;
  logic        clear;
  logic [31:0] ext_data;
  logic        ext_strobe;
  logic        ext_ready;
  logic        PortInout;
  logic [31:0] bus_out;
  logic        data_valid;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;
  logic [6:0]  dut_status;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_unf;

  in_port_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut (
    .clock(clock), .clear(clear), .ext_data(ext_data), .ext_strobe(ext_strobe),
    .ext_ready(ext_ready), .PortInout(PortInout), .bus_out(bus_out),
    .data_valid(data_valid), .count(count), .overflow(overflow), .underflow(underflow)
  );

  assign dut_status = {count, data_valid, ext_ready, overflow, underflow};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic logic [6:0] exp_status();
    int unsigned n;
    n = q.size();
    return {3'(n), n != 0, n < 4, m_ovf, m_unf};
  endfunction

  function automatic void model_push(input logic [31:0] d);
    if (q.size() < 4) q.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_pop();
    if (q.size() != 0) void'(q.pop_front());
    else m_unf = 1'b1;
  endfunction

  task automatic do_clear(input int unsigned cycles);
    clear = 1'b1;
    repeat (cycles) @(negedge clock);
    clear = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Strobe high for one sampled edge; word lands two edges later.
  task automatic push_word(input logic [31:0] d, input bit check_latency);
    ext_data   = d;
    ext_strobe = 1'b1;
    @(negedge clock);
    ext_strobe = 1'b0;
    @(negedge clock);
    if (check_latency) begin
      n_tests++;
      if (data_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL push_latency_early: data_valid got %b expected %b", data_valid, q.size() != 0);
      end
    end
    @(negedge clock);
    model_push(d);
    n_tests++;
    if (dut_status !== exp_status()) begin
      n_fail++;
      $display("FAIL push_status: {count,valid,ready,ovf,unf} got %b expected %b", dut_status, exp_status());
    end
  endtask

  task automatic held_read(input int unsigned cycles, output logic [31:0] first);
    logic [31:0] exp;
    first = '0;
    PortInout = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) begin
      #1;
      exp = (q.size() != 0) ? q[0] : 32'h0;
      if (i == 0) first = bus_out;
      n_tests++;
      if (bus_out !== exp) begin
        n_fail++;
        $display("FAIL read_bus cycle %0d: bus_out got %h expected %h", i, bus_out, exp);
      end
      @(negedge clock);
      if (i == 0) model_pop();
    end
    PortInout = 1'b0;
    n_tests++;
    if (dut_status !== exp_status()) begin
      n_fail++;
      $display("FAIL read_status: {count,valid,ready,ovf,unf} got %b expected %b", dut_status, exp_status());
    end
    @(negedge clock);
  endtask

  // PortInout asserted for the cycle that ends at the push's write edge.
  task automatic push_pop(input logic [31:0] d);
    logic [31:0] exp;
    ext_data   = d;
    ext_strobe = 1'b1;
    @(negedge clock);
    ext_strobe = 1'b0;
    @(negedge clock);
    PortInout = 1'b1;
    #1;
    exp = (q.size() != 0) ? q[0] : 32'h0;
    n_tests++;
    if (bus_out !== exp) begin
      n_fail++;
      $display("FAIL push_pop_bus: bus_out got %h expected %h", bus_out, exp);
    end
    @(negedge clock);
    PortInout = 1'b0;
    model_pop();
    model_push(d);
    n_tests++;
    if (dut_status !== exp_status()) begin
      n_fail++;
      $display("FAIL push_pop_status: {count,valid,ready,ovf,unf} got %b expected %b", dut_status, exp_status());
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_clear(2);
    n_tests++;
    if (dut_status !== 7'b000_0_1_0_0) begin
      n_fail++;
      $display("FAIL reset_status: {count,valid,ready,ovf,unf} got %b expected %b", dut_status, 7'b000_0_1_0_0);
    end
    n_tests++;
    if (bus_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: bus_out got %h expected %h", bus_out, 32'h0);
    end
  endtask

  task automatic test_single_push_read();
    logic [31:0] got;
    push_word(32'hDEADBEEF, 1'b1);
    held_read(1, got);
    n_tests++;
    if (got !== 32'hDEADBEEF || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_read: word got %h expected deadbeef, count got %0d expected 0", got, count);
    end
  endtask

  task automatic test_order_wrap();
    logic [31:0] got;
    logic [31:0] exp_seq [4];
    exp_seq = '{32'd3, 32'd4, 32'd5, 32'd6};
    do_clear(1);
    for (int unsigned i = 1; i <= 4; i++) push_word(32'(i), 1'b0);
    n_tests++;
    if (count !== 3'd4 || ext_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL order_full: count/ready got %0d/%b expected 4/0", count, ext_ready);
    end
    for (int unsigned i = 1; i <= 2; i++) begin
      held_read(1, got);
      n_tests++;
      if (got !== 32'(i)) begin
        n_fail++;
        $display("FAIL order_first: word got %h expected %h", got, 32'(i));
      end
    end
    push_word(32'd5, 1'b0);
    push_word(32'd6, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      held_read(1, got);
      n_tests++;
      if (got !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL order_wrap: word got %h expected %h", got, exp_seq[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got;
    do_clear(1);
    for (int unsigned i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 1'b0);
    push_word(32'h99, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_flag: ovf/count got %b/%0d expected 1/4", overflow, count);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      held_read(1, got);
      n_tests++;
      if (got !== 32'hA0 + 32'(i)) begin
        n_fail++;
        $display("FAIL overflow_data: word got %h expected %h", got, 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_underflow_held();
    logic [31:0] got;
    do_clear(1);
    held_read(3, got);
    n_tests++;
    if (underflow !== 1'b1 || got !== 32'h0) begin
      n_fail++;
      $display("FAIL underflow: unf/bus got %b/%h expected 1/0", underflow, got);
    end
    do_clear(1);
    push_word(32'hAAAA_0001, 1'b0);
    push_word(32'hBBBB_0002, 1'b0);
    held_read(3, got);
    n_tests++;
    if (count !== 3'd1 || got !== 32'hAAAA_0001 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL held_read: count/word/unf got %0d/%h/%b expected 1/aaaa0001/0", count, got, underflow);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] got;
    do_clear(1);
    for (int unsigned i = 0; i < 4; i++) push_word(32'h10 + 32'(i), 1'b0);
    push_pop(32'h5A5A_5A5A);
    n_tests++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_full: count/ovf got %0d/%b expected 4/0", count, overflow);
    end
    for (int unsigned i = 0; i < 4; i++) held_read(1, got);
    n_tests++;
    if (got !== 32'h5A5A_5A5A) begin
      n_fail++;
      $display("FAIL simul_last: word got %h expected 5a5a5a5a", got);
    end
    push_pop(32'h0000_00EE);
    n_tests++;
    if (count !== 3'd1 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_empty: count/unf got %0d/%b expected 1/1", count, underflow);
    end
  endtask

  task automatic test_clear_midstream();
    do_clear(1);
    for (int unsigned i = 0; i < 3; i++) push_word(32'h77 + 32'(i), 1'b0);
    do_clear(1);
    n_tests++;
    if (count !== 3'd0 || data_valid !== 1'b0 || ext_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_mid: count/valid/ready got %0d/%b/%b expected 0/0/1", count, data_valid, ext_ready);
    end
  endtask

  task automatic test_strobe_through_clear();
    logic [31:0] got;
    ext_data   = 32'hC0FF_EE00;
    ext_strobe = 1'b1;
    do_clear(2);
    for (int unsigned e = 1; e <= 3; e++) begin
      @(negedge clock);
      n_tests++;
      if (count !== ((e == 3) ? 3'd1 : 3'd0)) begin
        n_fail++;
        $display("FAIL strobe_clear edge %0d: count got %0d expected %0d", e, count, (e == 3) ? 1 : 0);
      end
    end
    model_push(32'hC0FF_EE00);
    repeat (2) @(negedge clock);
    ext_strobe = 1'b0;
    repeat (3) @(negedge clock);
    held_read(1, got);
    n_tests++;
    if (got !== 32'hC0FF_EE00 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL strobe_clear_once: word/count got %h/%0d expected c0ffee00/0", got, count);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    do_clear(1);
    for (int unsigned n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    push_word($urandom(), 1'b0);
        2:       held_read($urandom_range(1, 3), got);
        default: push_pop($urandom());
      endcase
    end
  endtask

  initial begin
    clear      = 1'b1;
    ext_data   = '0;
    ext_strobe = 1'b0;
    PortInout  = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    @(negedge clock);
    test_reset();
    test_single_push_read();
    test_order_wrap();
    test_overflow();
    test_underflow_held();
    test_simultaneous();
    test_clear_midstream();
    test_strobe_through_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
